// File: rtl/wbram_loader.sv
// wbram_loader: writes a weight stream round-robin into double-buffered BRAM banks and hands off filled buffers
module wbram_loader #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS = 16,
  parameter int WBRAM_DEPTH = 512,
  localparam int AW = $clog2(WBRAM_DEPTH),
  localparam int CW = $clog2(WBRAM_DEPTH/2) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CW-1:0]                          cfg_beats,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [STREAM_WIDTH-1:0]                s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic                                   s_last,
  output logic [NUM_BANKS-1:0][AW-1:0]           addrA,
  output logic [NUM_BANKS-1:0][STREAM_WIDTH-1:0] doA,
  output logic [NUM_BANKS-1:0]                   enaA,
  output logic [NUM_BANKS-1:0]                   weA,
  output logic [1:0]                             wr_pointer_data_r,
  output logic                                   wr_pointer_valid_r,
  input  logic                                   wr_pointer_ready_r,
  input  logic [1:0]                             rd_pointer_data_l,
  input  logic                                   rd_pointer_valid_l,
  output logic                                   rd_pointer_ready_l,
  output logic                                   err
);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int WW = AW - 1;
  localparam logic [CW-1:0] HALF = CW'(WBRAM_DEPTH/2);
  localparam logic [BW-1:0] BLAST = BW'(NUM_BANKS-1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_BUF = 2'd1, LOAD = 2'd2, PUBLISH = 2'd3;
  logic [1:0] state, buf_free, free_nxt;
  logic wr_buf, acc, fin, take, unused;
  logic [CW-1:0] n;
  logic [BW-1:0] bank;
  logic [WW-1:0] word;
  logic [NUM_BANKS-1:0] ena;
  assign unused = rd_pointer_data_l[1];
  assign cfg_ready = state == IDLE && !rst;
  assign s_ready = state == LOAD;
  assign rd_pointer_ready_l = 1'b1;
  assign wr_pointer_valid_r = state == PUBLISH;
  assign wr_pointer_data_r = wr_pointer_valid_r ? {1'b0, wr_buf} : 2'b00;
  assign enaA = ena;
  assign weA = ena;
  // a release landing in the same cycle as the buffer claim counts as free
  always_comb begin
    acc = state == LOAD && s_valid;
    fin = CW'(word) == n - CW'(1) && bank == BLAST;
    free_nxt = buf_free | (rd_pointer_valid_l ? 2'b01 << rd_pointer_data_l[0] : 2'b00);
    take = state == WAIT_BUF && free_nxt[wr_buf];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_buf <= 1'b0;
      buf_free <= 2'b11;
      err <= 1'b0;
      n <= '0;
      bank <= '0;
      word <= '0;
      ena <= '0;
      addrA <= '0;
      doA <= '0;
    end else begin
      ena <= '0;
      buf_free <= free_nxt;
      if (take) buf_free[wr_buf] <= 1'b0;
      if (acc) begin
        ena[bank] <= 1'b1;
        addrA[bank] <= {wr_buf, word};
        doA[bank] <= s_data;
        bank <= bank == BLAST ? '0 : bank + 1'b1;
        word <= word + WW'(bank == BLAST);
        if (s_last != fin) err <= 1'b1;
      end
      case (state)
        IDLE: if (cfg_valid) begin
          n <= cfg_beats > HALF ? HALF : cfg_beats;
          if (cfg_beats != '0) state <= WAIT_BUF;
        end
        WAIT_BUF: if (take) begin
          bank <= '0;
          word <= '0;
          state <= LOAD;
        end
        LOAD: if (acc && (fin || s_last)) state <= PUBLISH;
        default: if (wr_pointer_ready_r) begin
          wr_buf <= ~wr_buf;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/wbram_loader.md
WBRAM_LOADER -- requirements
Module: wbram_loader

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 128: weight-stream beat width and BRAM write width, in bits.
REQ-002 SHALL have parameter NUM_BANKS, default 16: number of weight BRAM banks.
REQ-003 SHALL have parameter WBRAM_DEPTH, default 512: words per bank; two halves of WBRAM_DEPTH/2 words (buffer 0 = low half, buffer 1 = high half).
REQ-004 SHALL define AW = $clog2(WBRAM_DEPTH) and CW = $clog2(WBRAM_DEPTH/2)+1.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Ports (name / direction / width / meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_beats  in  CW  words per bank for the next layer.
- cfg_valid  in  1; cfg_ready  out  1  config handshake.
- s_data  in  STREAM_WIDTH  weight beat.
- s_valid  in  1; s_ready  out  1; s_last  in  1  weight stream.
- addrA  out  NUM_BANKS x AW  per-bank write address.
- doA  out  NUM_BANKS x STREAM_WIDTH  per-bank write data.
- enaA, weA  out  NUM_BANKS  per-bank enable / write enable.
- wr_pointer_data_r  out  2; wr_pointer_valid_r  out  1; wr_pointer_ready_r  in  1  filled-buffer pointer to the read controller.
- rd_pointer_data_l  in  2; rd_pointer_valid_l  in  1; rd_pointer_ready_l  out  1  buffer-release pointer from the read controller.
- err  out  1  sticky length-mismatch flag.

Function
REQ-007 FSM states SHALL be IDLE, WAIT_BUF, LOAD, PUBLISH; reset state IDLE.
REQ-008 IDLE: cfg_ready=1; on cfg handshake latch N = min(cfg_beats, WBRAM_DEPTH/2). N=0: stay in IDLE, no load, no pointer. Otherwise go to WAIT_BUF.
REQ-009 WAIT_BUF: when buf_free[wr_buf]=1, clear buf_free[wr_buf], zero the beat counter, go to LOAD. A release of wr_buf in the same cycle SHALL count as free.
REQ-010 LOAD: s_ready=1. Beat k (0-based) is accepted on s_valid&s_ready. It SHALL go to bank k mod NUM_BANKS at address {wr_buf, k div NUM_BANKS}.
REQ-011 The write SHALL be registered: enaA[b]=weA[b]=1, with addrA[b] and doA[b] valid, for exactly the one cycle after the accepting edge. All other banks have enaA=weA=0 in that cycle.
REQ-012 LOAD SHALL end on the beat k = N*NUM_BANKS-1, or earlier on s_last, then go to PUBLISH.
REQ-013 err SHALL be set if s_last=1 on a beat other than the final one, or s_last=0 on the final beat. err stays set until reset. The load still publishes.
REQ-014 PUBLISH: wr_pointer_valid_r=1 and wr_pointer_data_r={1'b0, wr_buf}, both held stable until wr_pointer_ready_r=1.
- On the handshake, toggle wr_buf and go to IDLE.
- The final BRAM write SHALL complete no later than the first cycle wr_pointer_valid_r is high.
REQ-015 rd_pointer_ready_l SHALL be 1 at all times. On rd_pointer_valid_l, set buf_free[rd_pointer_data_l[0]]. Releasing a buffer that is already free has no effect. rd_pointer_data_l[1] is ignored.
REQ-016 Throughput: one beat per cycle with no bubbles in LOAD. s_ready=0 in every state other than LOAD.
REQ-017 Counter widths SHALL cover N*NUM_BANKS without overflow. The bank index wraps from NUM_BANKS-1 to 0 and increments the word offset.

Reset
REQ-018 On rst, SHALL drive immediately, without waiting for clk:
- state=IDLE, wr_buf=0, buf_free=2'b11, err=0, counters 0.
- enaA=weA=0, addrA=0, doA=0.
- s_ready=0, cfg_ready=0 while rst is high, then 1 in IDLE.
- wr_pointer_valid_r=0, wr_pointer_data_r=0.
REQ-019 Reset during LOAD or PUBLISH SHALL abandon the transfer with no pointer emitted. Both buffers are considered free afterwards.

Verification
REQ-020 Bench scenarios:
- NUM_BANKS=16, cfg_beats=2, 32 beats with s_last on beat 31: bank b gets addr 0 (beat b) and addr 1 (beat 16+b); pointer 0 published; err=0.
- Two back-to-back layers with the first pointer never released: the second layer loads buffer 1 (addrA[8]=1 for DEPTH=512); the third layer stalls in WAIT_BUF with s_ready=0 until rd_pointer_data_l=0 is accepted.
- s_last on beat 10 of 32: transfer ends after 11 writes; pointer published; err=1 and stays 1.
- wr_pointer_ready_r held 0 for 20 cycles: wr_pointer_valid_r and wr_pointer_data_r stay stable; cfg_ready=0 throughout.
- cfg_beats=0: accepted, no writes, no pointer. cfg_beats=300 (DEPTH 512): clamped to 256, so 4096 beats.
- rst asserted mid-LOAD: all outputs at reset values asynchronously; next layer loads buffer 0.
